demux_4way_reg: RTL and testbench

DEMUX_4WAY_REG -- requirements
Module: demux_4way_reg

---
 rtl/demux_4way_reg.sv | 69 ++++++
 tb/tb_demux_4way_reg.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/demux_4way_reg.sv
// Four-lane registered demultiplexer: one input stream steered to one of four one-entry
// output buffers, each with a valid/ready handshake and an 8-bit delivery counter.
module demux_4way_reg #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       in_sel,
   input  logic [WIDTH-1:0] in_data,
   output logic [3:0]       out_valid,
   input  logic [3:0]       out_ready,
   output logic [WIDTH-1:0] out_data0,
   output logic [WIDTH-1:0] out_data1,
   output logic [WIDTH-1:0] out_data2,
   output logic [WIDTH-1:0] out_data3,
   input  logic             cnt_clr,
   output logic [31:0]      lane_count,
   output logic             busy
);

   logic [3:0]       valid_q, valid_d;
   logic [WIDTH-1:0] data_q [4];
   logic [7:0]       cnt_q  [4];
   logic             accept;
   logic [3:0]       load;
   logic [3:0]       deq;

   // Only the selected lane gates the input, so a stalled lane never blocks the others.
   always_comb begin
      in_ready = ~valid_q[in_sel] | out_ready[in_sel];
      accept   = in_valid & in_ready;
      deq      = valid_q & out_ready;
      load     = '0;
      valid_d  = '0;
      for (int i = 0; i < 4; i++) begin
         load[i]    = accept && (in_sel == 2'(i));
         valid_d[i] = load[i] | (valid_q[i] & ~deq[i]);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_q <= '0;
         for (int i = 0; i < 4; i++) begin
            data_q[i] <= '0;
            cnt_q[i]  <= '0;
         end
      end else begin
         valid_q <= valid_d;
         for (int i = 0; i < 4; i++) begin
            if (load[i]) data_q[i] <= in_data;
            // Clear wins over a same-cycle delivery.
            if (cnt_clr)     cnt_q[i] <= '0;
            else if (deq[i]) cnt_q[i] <= cnt_q[i] + 8'd1;
         end
      end
   end

   assign out_valid  = valid_q;
   assign out_data0  = data_q[0];
   assign out_data1  = data_q[1];
   assign out_data2  = data_q[2];
   assign out_data3  = data_q[3];
   assign lane_count = {cnt_q[3], cnt_q[2], cnt_q[1], cnt_q[0]};
   assign busy       = |valid_q;

endmodule

// File: tb/tb_demux_4way_reg.sv
// Bench for demux_4way_reg: directed scenarios plus randomized traffic against a
// per-lane buffer/counter reference model.
module tb_demux_4way_reg;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  in_sel;
   logic [31:0] in_data;
   logic [3:0]  out_valid;
   logic [3:0]  out_ready;
   logic [31:0] out_data0, out_data1, out_data2, out_data3;
   logic        cnt_clr;
   logic [31:0] lane_count;
   logic        busy;

   int nchk  = 0;
   int npass = 0;

   // Reference model: one entry per lane plus a delivery count.
   bit          mvalid [4];
   logic [31:0] mdata  [4];
   logic [7:0]  mcnt   [4];

   demux_4way_reg #(.WIDTH(32)) dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_sel     (in_sel),
      .in_data    (in_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data0  (out_data0),
      .out_data1  (out_data1),
      .out_data2  (out_data2),
      .out_data3  (out_data3),
      .cnt_clr    (cnt_clr),
      .lane_count (lane_count),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      nchk++;
      if (got !== exp) $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      else npass++;
   endtask

   task automatic model_clear();
      for (int i = 0; i < 4; i++) begin
         mvalid[i] = 1'b0;
         mdata[i]  = '0;
         mcnt[i]   = '0;
      end
   endtask

   function automatic bit model_ready();
      return !mvalid[in_sel] || out_ready[in_sel];
   endfunction

   task automatic check_outputs(input string tag);
      logic [3:0]  ev;
      logic [31:0] ec;
      bit          eb;
      eb = 1'b0;
      for (int i = 0; i < 4; i++) begin
         ev[i] = mvalid[i];
         ec[8*i +: 8] = mcnt[i];
         eb = eb | mvalid[i];
      end
      check({tag, ".out_valid"}, 64'(out_valid), 64'(ev));
      check({tag, ".out_data0"}, 64'(out_data0), 64'(mdata[0]));
      check({tag, ".out_data1"}, 64'(out_data1), 64'(mdata[1]));
      check({tag, ".out_data2"}, 64'(out_data2), 64'(mdata[2]));
      check({tag, ".out_data3"}, 64'(out_data3), 64'(mdata[3]));
      check({tag, ".lane_count"}, 64'(lane_count), 64'(ec));
      check({tag, ".busy"}, 64'(busy), 64'(eb));
   endtask

   // Called just after a negedge with inputs already driven; ends at the next negedge.
   task automatic step(input string tag);
      bit acc;
      #1;
      check({tag, ".in_ready"}, 64'(in_ready), 64'(model_ready()));
      acc = in_valid && model_ready();
      @(posedge clk);
      for (int i = 0; i < 4; i++) begin
         bit d;
         d = mvalid[i] && out_ready[i];
         if (cnt_clr) mcnt[i] = 8'd0;
         else if (d)  mcnt[i] = mcnt[i] + 8'd1;
         if (acc && in_sel == 2'(i)) begin
            mvalid[i] = 1'b1;
            mdata[i]  = in_data;
         end else if (d) begin
            mvalid[i] = 1'b0;
         end
      end
      #1;
      check_outputs(tag);
      @(negedge clk);
   endtask

   task automatic drive(input bit v, input logic [1:0] s, input logic [31:0] d,
                        input logic [3:0] r, input bit c);
      in_valid  = v;
      in_sel    = s;
      in_data   = d;
      out_ready = r;
      cnt_clr   = c;
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      model_clear();
   endtask

   initial begin
      model_clear();
      reset = 1'b1;
      // Input presented during reset must not load anything.
      drive(1'b1, 2'b10, 32'h1234_5678, 4'b0000, 1'b0);
      #1;
      check("rst.in_ready", 64'(in_ready), 64'd1);
      repeat (2) @(posedge clk);
      #1;
      check_outputs("rst");
      @(negedge clk);
      reset = 1'b0;

      // Single word to lane 2.
      drive(1'b1, 2'b10, 32'hCAFE_0002, 4'b0000, 1'b0);
      step("lane2");
      check("lane2.vec", 64'(out_valid), 64'h4);
      check("lane2.data", 64'(out_data2), 64'hCAFE_0002);
      check("lane2.busy", 64'(busy), 64'd1);

      // Backpressure on lane 1.
      drive(1'b1, 2'b01, 32'hAAAA_0001, 4'b0000, 1'b0);
      step("l1.fill");
      drive(1'b1, 2'b01, 32'hBBBB_0001, 4'b0000, 1'b0);
      #1;
      check("l1.stall_ready", 64'(in_ready), 64'd0);
      #0;
      @(negedge clk);
      check("l1.hold", 64'(out_data1), 64'hAAAA_0001);
      out_ready = 4'b0010;
      #1;
      check("l1.release_ready", 64'(in_ready), 64'd1);
      step("l1.release");
      check("l1.newdata", 64'(out_data1), 64'hBBBB_0001);

      // Back-to-back round-robin stream, fresh counters.
      pulse_reset();
      for (int k = 0; k < 8; k++) begin
         drive(1'b1, 2'(k), 32'h5000_0000 + 32'(k), 4'b1111, 1'b0);
         step("stream");
      end
      drive(1'b0, 2'b00, 32'h0, 4'b1111, 1'b0);
      step("stream.drain");
      check("stream.count", 64'(lane_count), 64'h0202_0202);

      // Async reset between edges with lanes 0 and 3 full.
      drive(1'b1, 2'b00, 32'h0000_00A0, 4'b0000, 1'b0);
      step("ar.l0");
      drive(1'b1, 2'b11, 32'h0000_00A3, 4'b0000, 1'b0);
      step("ar.l3");
      drive(1'b0, 2'b00, 32'h0, 4'b0000, 1'b0);
      #2 reset = 1'b1;
      #1;
      check("ar.valid", 64'(out_valid), 64'h0);
      check("ar.count", 64'(lane_count), 64'h0);
      #1 reset = 1'b0;
      model_clear();
      @(negedge clk);
      step("ar.after");

      // Lane 3 counter wrap, then clear beating a lane 0 delivery.
      for (int k = 0; k < 256; k++) begin
         drive(1'b1, 2'b11, 32'(k), 4'b1000, 1'b0);
         step("wrap.fill");
      end
      check("wrap.255", 64'(lane_count[31:24]), 64'd255);
      drive(1'b0, 2'b00, 32'h0, 4'b1000, 1'b0);
      step("wrap.deq");
      check("wrap.zero", 64'(lane_count[31:24]), 64'd0);
      drive(1'b1, 2'b00, 32'hD00D_0000, 4'b0000, 1'b0);
      step("clr.load");
      drive(1'b0, 2'b00, 32'h0, 4'b0001, 1'b1);
      step("clr.deq");
      check("clr.lane0", 64'(lane_count[7:0]), 64'd0);

      // Randomized traffic.
      for (int k = 0; k < 400; k++) begin
         drive(1'($urandom_range(0, 3) != 0), 2'($urandom), $urandom, 4'($urandom),
               1'($urandom_range(0, 15) == 0));
         step("rand");
      end

      $display("%0d/%0d checks passed", npass, nchk);
      $finish;
   end

endmodule
